// File: rtl/palette_ram_arbiter.sv
// Shares one 8-bit synchronous palette RAM between per-pixel colour fetches (always first) and
// 68000 word accesses that are acknowledged with real DTACK wait states. Option: PALARB_STALL_CNT_EN.
module palette_ram_arbiter #(
   parameter int ADDR_W      = 14,
   parameter int CLK_PER_PIX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce_pixel,
   input  logic [ADDR_W-1:0] vid_index,
   output logic [15:0]       vid_color,
   output logic              vid_valid,
   input  logic              cpu_cs,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rwn,
   input  logic              cpu_udsn,
   input  logic              cpu_ldsn,
   input  logic [15:0]       cpu_din,
   output logic [15:0]       cpu_dout,
   output logic              cpu_dtackn,
   output logic [ADDR_W:0]   ram_addr,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din,
   output logic              ram_wen
`ifdef PALARB_STALL_CNT_EN
   ,
   input  logic              stall_clr,
   output logic [15:0]       stall_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE, VID_LO, VID_HI, VID_DONE, CPU_LO, CPU_HI, CPU_DONE
   } state_t;

   state_t            state;
   logic              vid_pend;
   logic              cpu_busy;
   logic [ADDR_W-1:0] vid_idx_q;
   logic [ADDR_W-1:0] cpu_addr_q;
   logic              cpu_rwn_q;
   logic              cpu_udsn_q;
   logic [7:0]        cpu_din_hi_q;
   logic [7:0]        lo_byte;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_next_idx;
   logic              cpu_active;

   // A same-cycle ce_pixel always supersedes whatever index is pending.
   assign vid_req      = vid_pend | ce_pixel;
   assign vid_next_idx = ce_pixel ? vid_index : vid_idx_q;
   assign cpu_active   = (state == CPU_LO) || (state == CPU_HI) || (state == CPU_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         vid_pend     <= 1'b0;
         cpu_busy     <= 1'b0;
         vid_idx_q    <= '0;
         cpu_addr_q   <= '0;
         cpu_rwn_q    <= 1'b1;
         cpu_udsn_q   <= 1'b1;
         cpu_din_hi_q <= '0;
         lo_byte      <= '0;
         vid_color    <= '0;
         vid_valid    <= 1'b0;
         cpu_dout     <= '0;
         cpu_dtackn   <= 1'b1;
         ram_addr     <= '0;
         ram_dout     <= '0;
         ram_wen      <= 1'b0;
      end else begin
         vid_valid <= 1'b0;
         ram_wen   <= 1'b0;

         if (ce_pixel) begin
            vid_pend  <= 1'b1;
            vid_idx_q <= vid_index;
         end

         // DTACK stays low until the CPU drops chip select.
         if (cpu_busy && !cpu_dtackn && !cpu_cs) begin
            cpu_dtackn <= 1'b1;
            cpu_busy   <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (vid_req) begin
                  state    <= VID_LO;
                  ram_addr <= {vid_next_idx, 1'b0};
               end else if (cpu_cs && !cpu_busy && (!cpu_udsn || !cpu_ldsn)) begin
                  state        <= CPU_LO;
                  cpu_busy     <= 1'b1;
                  cpu_addr_q   <= cpu_addr;
                  cpu_rwn_q    <= cpu_rwn;
                  cpu_udsn_q   <= cpu_udsn;
                  cpu_din_hi_q <= cpu_din[15:8];
                  ram_addr     <= {cpu_addr, 1'b0};
                  ram_wen      <= ~cpu_rwn & ~cpu_ldsn;
                  if (!cpu_rwn)
                     ram_dout <= cpu_din[7:0];
               end
            end
            // The in-flight word address lives in ram_addr, so a new ce_pixel
            // here only queues the next fetch.
            VID_LO: begin
               if (!ce_pixel)
                  vid_pend <= 1'b0;
               ram_addr <= {ram_addr[ADDR_W:1], 1'b1};
               state    <= VID_HI;
            end
            VID_HI: begin
               lo_byte <= ram_din;
               state   <= VID_DONE;
            end
            VID_DONE: begin
               vid_color <= {ram_din, lo_byte};
               vid_valid <= 1'b1;
               state     <= IDLE;
            end
            CPU_LO: begin
               ram_addr <= {cpu_addr_q, 1'b1};
               if (!cpu_rwn_q) begin
                  ram_wen  <= ~cpu_udsn_q;
                  ram_dout <= cpu_din_hi_q;
               end
               state <= CPU_HI;
            end
            CPU_HI: begin
               lo_byte <= ram_din;
               state   <= CPU_DONE;
            end
            CPU_DONE: begin
               if (cpu_rwn_q)
                  cpu_dout <= {ram_din, lo_byte};
               cpu_dtackn <= 1'b0;
               if (vid_req) begin
                  state    <= VID_LO;
                  ram_addr <= {vid_next_idx, 1'b0};
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PALARB_STALL_CNT_EN
   logic stall_evt;

   // VID_LO still shows vid_pend for the fetch already under way, which is not an overwrite.
   assign stall_evt = ce_pixel && (cpu_active || (vid_pend && (state != VID_LO)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall_clr)
         stall_cnt <= '0;
      else if (stall_evt && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`else
   logic unused_cpu_active;
   assign unused_cpu_active = cpu_active;
`endif

   always @(posedge clk) begin
      assert (CLK_PER_PIX >= 6) else $error("CLK_PER_PIX must be at least 6");
   end

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Scoreboard bench for palette_ram_arbiter: stimulus pushes expected colour/read words with their
// arrival cycle, a monitor pops them on vid_valid and on each falling DTACK.
module tb_palette_ram_arbiter;
   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ce_pixel = 1'b0;
   logic [ADDR_W-1:0] vid_index = '0;
   logic [15:0]       vid_color;
   logic              vid_valid;
   logic              cpu_cs = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic              cpu_rwn = 1'b1;
   logic              cpu_udsn = 1'b1;
   logic              cpu_ldsn = 1'b1;
   logic [15:0]       cpu_din = '0;
   logic [15:0]       cpu_dout;
   logic              cpu_dtackn;
   logic [ADDR_W:0]   ram_addr;
   logic [7:0]        ram_dout;
   logic [7:0]        ram_din = '0;
   logic              ram_wen;
`ifdef PALARB_STALL_CNT_EN
   logic              stall_clr = 1'b0;
   logic [15:0]       stall_cnt;
`endif

   palette_ram_arbiter #(.ADDR_W(ADDR_W), .CLK_PER_PIX(8)) dut (
      .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .vid_index(vid_index),
      .vid_color(vid_color), .vid_valid(vid_valid), .cpu_cs(cpu_cs), .cpu_addr(cpu_addr),
      .cpu_rwn(cpu_rwn), .cpu_udsn(cpu_udsn), .cpu_ldsn(cpu_ldsn), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_dtackn(cpu_dtackn), .ram_addr(ram_addr), .ram_dout(ram_dout),
      .ram_din(ram_din), .ram_wen(ram_wen)
`ifdef PALARB_STALL_CNT_EN
      , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Byte-wide synchronous RAM model with a bench-side preload port.
   logic [7:0]    mem [0:32767];
   logic          pre_we = 1'b0;
   logic [14:0]   pre_addr = '0;
   logic [7:0]    pre_data = '0;
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (ram_wen)
         mem[ram_addr] <= ram_dout;
      ram_din <= mem[ram_addr];
   end

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t vid_q[$];
   exp_t cpu_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Monitor: compares whatever the DUT presents against the head of each queue.
   initial begin
      exp_t e;
      logic dtackn_prev;
      dtackn_prev = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (vid_valid) begin
            if (vid_q.size() == 0) begin
               chk("vid_unexpected", int'(vid_color), -1);
            end else begin
               e = vid_q.pop_front();
               chk("vid_color", int'(vid_color), int'(e.data));
               chk("vid_cycle", cyc, e.cyc);
            end
         end
         if (dtackn_prev && !cpu_dtackn) begin
            if (cpu_q.size() == 0) begin
               chk("dtack_unexpected", int'(cpu_dout), -1);
            end else begin
               e = cpu_q.pop_front();
               chk("cpu_dout", int'(cpu_dout), int'(e.data));
               chk("dtack_cycle", cyc, e.cyc);
            end
         end
         dtackn_prev = cpu_dtackn;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic poke(input logic [14:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   task automatic cpu_start(input logic [13:0] a, input logic rwn, input logic uds,
                            input logic lds, input logic [15:0] din);
      cpu_cs   = 1'b1;
      cpu_addr = a;
      cpu_rwn  = rwn;
      cpu_udsn = uds;
      cpu_ldsn = lds;
      cpu_din  = din;
   endtask

   task automatic cpu_finish(input int hold, input logic [14:0] hold_addr);
      int n;
      n = 0;
      while (cpu_dtackn && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk("dtack_asserted", int'(cpu_dtackn), 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("dtack_held", int'(cpu_dtackn), 0);
         chk("no_retrigger", int'(ram_addr), int'(hold_addr));
      end
      cpu_cs   = 1'b0;
      cpu_rwn  = 1'b1;
      cpu_udsn = 1'b1;
      cpu_ldsn = 1'b1;
      @(negedge clk);
      chk("dtack_release", int'(cpu_dtackn), 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_vid_color", int'(vid_color), 0);
      chk("rst_vid_valid", int'(vid_valid), 0);
      chk("rst_cpu_dout", int'(cpu_dout), 0);
      chk("rst_dtackn", int'(cpu_dtackn), 1);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_ram_dout", int'(ram_dout), 0);
      chk("rst_ram_wen", int'(ram_wen), 0);
   endtask

   initial begin
      int base;
      int n;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;
      @(negedge clk);

      // Video fetch of word 0x0123 from IDLE.
      poke(15'h0246, 8'hC3);
      poke(15'h0247, 8'hA5);
      base = cyc;
      ce_pixel  = 1'b1;
      vid_index = 14'h0123;
      vid_q.push_back('{data: 16'hA5C3, cyc: base + 4});
      @(negedge clk);
      ce_pixel = 1'b0;
      chk("vid_addr_lo", int'(ram_addr), 'h246);
      @(negedge clk);
      chk("vid_addr_hi", int'(ram_addr), 'h247);
      @(negedge clk);
      @(negedge clk);
      chk("vid_valid_on", int'(vid_valid), 1);
      @(negedge clk);
      chk("vid_valid_off", int'(vid_valid), 0);

      // Upper-byte-only write to word 0x0010.
      poke(15'h0020, 8'h77);
      poke(15'h0021, 8'h00);
      base = cyc;
      cpu_start(14'h0010, 1'b0, 1'b0, 1'b1, 16'h1234);
      cpu_q.push_back('{data: 16'h0000, cyc: base + 4});
      cpu_finish(3, 15'h0021);
      chk("wr_hi_byte", int'(mem[15'h0021]), 'h12);
      chk("wr_lo_untouched", int'(mem[15'h0020]), 'h77);

      // Word read; cs held high must not start a second access.
      poke(15'h0020, 8'hEF);
      poke(15'h0021, 8'hBE);
      base = cyc;
      cpu_start(14'h0010, 1'b1, 1'b0, 1'b0, 16'h0000);
      cpu_q.push_back('{data: 16'hBEEF, cyc: base + 4});
      cpu_finish(5, 15'h0021);
      chk("rd_dout_held", int'(cpu_dout), 'hBEEF);

      // Read with only the lower strobe still returns both bytes.
      poke(15'h0022, 8'h55);
      poke(15'h0023, 8'h66);
      base = cyc;
      cpu_start(14'h0011, 1'b1, 1'b1, 1'b0, 16'h0000);
      cpu_q.push_back('{data: 16'h6655, cyc: base + 4});
      cpu_finish(1, 15'h0023);

      // ce_pixel while the CPU sequence is in CPU_LO.
      poke(15'h0400, 8'h34);
      poke(15'h0401, 8'h12);
      poke(15'h0040, 8'hCD);
      poke(15'h0041, 8'hAB);
      base = cyc;
      cpu_start(14'h0020, 1'b1, 1'b0, 1'b0, 16'h0000);
      cpu_q.push_back('{data: 16'hABCD, cyc: base + 4});
      @(negedge clk);
      ce_pixel  = 1'b1;
      vid_index = 14'h0200;
      vid_q.push_back('{data: 16'h1234, cyc: base + 7});
      @(negedge clk);
      ce_pixel = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("vid_after_cpu_done", int'(ram_addr), 'h400);
      cpu_finish(0, 15'h0041);
      repeat (4) @(negedge clk);
`ifdef PALARB_STALL_CNT_EN
      chk("stall_cnt_one", int'(stall_cnt), 1);
      stall_clr = 1'b1;
      @(negedge clk);
      stall_clr = 1'b0;
      chk("stall_cnt_clr", int'(stall_cnt), 0);
`endif

      // ce_pixel and cs in the same IDLE cycle: video first, CPU right after.
      poke(15'h02A0, 8'h0F);
      poke(15'h02A1, 8'hF0);
      poke(15'h0060, 8'h22);
      poke(15'h0061, 8'h11);
      base = cyc;
      ce_pixel  = 1'b1;
      vid_index = 14'h0150;
      cpu_start(14'h0030, 1'b1, 1'b0, 1'b0, 16'h0000);
      vid_q.push_back('{data: 16'hF00F, cyc: base + 4});
      cpu_q.push_back('{data: 16'h1122, cyc: base + 8});
      @(negedge clk);
      ce_pixel = 1'b0;
      cpu_finish(0, 15'h0061);
`ifdef PALARB_STALL_CNT_EN
      chk("stall_cnt_tie", int'(stall_cnt), 0);
`endif

      // Reset during CPU_HI of a full-word write.
      cpu_start(14'h0030, 1'b0, 1'b0, 1'b0, 16'h5A6B);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      chk("abort_hi_unwritten", int'(mem[15'h0061]), 'h11);
      chk("abort_lo_written", int'(mem[15'h0060]), 'h6B);
      cpu_cs   = 1'b0;
      cpu_rwn  = 1'b1;
      cpu_udsn = 1'b1;
      cpu_ldsn = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_dtack", int'(cpu_dtackn), 1);
      end

      // Re-presented access after reset.
      base = cyc;
      cpu_start(14'h0030, 1'b1, 1'b0, 1'b0, 16'h0000);
      cpu_q.push_back('{data: 16'h116B, cyc: base + 4});
      cpu_finish(1, 15'h0061);

      n = 0;
      while ((vid_q.size() + cpu_q.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", vid_q.size() + cpu_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
